// File: rtl/pipeline_skid_reg.sv
// pipeline_skid_reg
// Pipeline stage register with valid/ready on both sides. It holds one main
// entry and one skid entry. Because of the skid entry, in_ready is decoded
// from registered state only and never combinationally from out_ready.
// A flush empties the stage. occupancy reports how many entries are held.
//
// Parameters:
//   DATA_W         payload width
//   CLEAR_ON_FLUSH 1 = zero the data registers on flush, 0 = leave them
//   CNT_W          width of the optional performance counters
//
// Ports:
//   CLK        clock, rising edge
//   RST        synchronous reset, active-high
//   flush      drop held entries and any same-cycle incoming beat
//   in_valid   upstream beat valid
//   in_ready   stage can accept a beat
//   in_data    upstream payload
//   out_valid  main entry valid
//   out_ready  downstream accepts
//   out_data   main entry payload
//   occupancy  entries held (0..2)
//   stall_cnt  (PIPELINE_SKID_REG_PERF_EN) cycles with in_valid & ~in_ready
//   flush_cnt  (PIPELINE_SKID_REG_PERF_EN) flushes that hit a non-empty stage
//
// Optional feature macro: PIPELINE_SKID_REG_PERF_EN adds the saturating
// stall_cnt and flush_cnt counters.
//
// state | meaning
// ------+-----------------------------------
// EMPTY | no entry held
// ONE   | main entry valid
// FULL  | main and skid entries valid, in_ready low
module pipeline_skid_reg #(
    parameter int DATA_W         = 32,
    parameter int CLEAR_ON_FLUSH = 1,
    parameter int CNT_W          = 16
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic [1:0]        occupancy
`ifdef PIPELINE_SKID_REG_PERF_EN
    ,
    output logic [CNT_W-1:0]  stall_cnt,
    output logic [CNT_W-1:0]  flush_cnt
`endif
);

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        FULL  = 2'd2
    } state_t;

    state_t            state;
    logic [DATA_W-1:0] main_q;
    logic [DATA_W-1:0] skid_q;
    logic              in_fire;
    logic              out_fire;

    if (CNT_W < 1) begin : g_bad_cnt_w
        $error("CNT_W must be at least 1");
    end

    assign out_valid = (state != EMPTY);
    assign out_data  = main_q;
    assign in_ready  = (state != FULL) & ~RST;
    // The enum encoding equals the entry count.
    assign occupancy = state;
    assign in_fire   = in_valid & in_ready;
    assign out_fire  = out_valid & out_ready;

    always_ff @(posedge CLK) begin
        if (RST) begin
            state  <= EMPTY;
            main_q <= '0;
            skid_q <= '0;
        end else if (flush) begin
            // A beat consumed downstream this cycle is still gone. The
            // incoming beat is dropped.
            state <= EMPTY;
            if (CLEAR_ON_FLUSH != 0) begin
                main_q <= '0;
                skid_q <= '0;
            end
        end else begin
            unique case (state)
                EMPTY: begin
                    if (in_fire) begin
                        state  <= ONE;
                        main_q <= in_data;
                    end
                end
                ONE: begin
                    if (in_fire && out_fire) begin
                        main_q <= in_data;
                    end else if (in_fire) begin
                        state  <= FULL;
                        skid_q <= in_data;
                    end else if (out_fire) begin
                        state <= EMPTY;
                    end
                end
                FULL: begin
                    // in_ready is low here, so only the drain can happen.
                    if (out_fire) begin
                        state  <= ONE;
                        main_q <= skid_q;
                    end
                end
                default: state <= EMPTY;
            endcase
        end
    end

`ifdef PIPELINE_SKID_REG_PERF_EN
    always_ff @(posedge CLK) begin
        if (RST) begin
            stall_cnt <= '0;
            flush_cnt <= '0;
        end else begin
            if (in_valid && !in_ready && (stall_cnt != {CNT_W{1'b1}})) begin
                stall_cnt <= stall_cnt + 1'b1;
            end
            if (flush && (state != EMPTY) && (flush_cnt != {CNT_W{1'b1}})) begin
                flush_cnt <= flush_cnt + 1'b1;
            end
        end
    end
`endif

endmodule
